// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and the ALU decoder.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_outdec.sv
// Moore output decode: maps a state code to the full datapath control bundle.
module multicycle_ctrl_outdec
  import multicycle_control_pkg::*;
(
  input  logic [3:0] i_state,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PCSRC_ALURESULT;
        o_ctrl.pc_write  = 1'b1;
      end
      // Branch target is precomputed here so BRANCH can load it from ALUOut.
      S_DECODE: begin
        o_ctrl.alu_src_b = ALUSRCB_IMM_SH;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_B;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
        o_ctrl.branch    = 1'b1;
      end
      S_ADDIWB: o_ctrl.reg_write = 1'b1;
      S_JUMP: begin
        o_ctrl.pc_src   = PCSRC_JUMP;
        o_ctrl.pc_write = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state
// logic, reset gating of the write enables and the PC enable.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_state_eff;
  ctrl_t      w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // During reset the decode sees FETCH so mux selects settle to their fetch values.
  assign w_state_eff = reset ? S_FETCH : r_state;

  multicycle_ctrl_outdec u_outdec (
    .i_state (w_state_eff),
    .o_ctrl  (w_ctrl)
  );

  assign IorD     = w_ctrl.iord;
  assign RegDst   = w_ctrl.reg_dst;
  assign MemtoReg = w_ctrl.mem_to_reg;
  assign ALUSrcA  = w_ctrl.alu_src_a;
  assign ALUSrcB  = w_ctrl.alu_src_b;
  assign ALUOp    = w_ctrl.alu_op;
  assign PCSrc    = w_ctrl.pc_src;
  assign MemWrite = w_ctrl.mem_write & ~reset;
  assign IRWrite  = w_ctrl.ir_write & ~reset;
  assign RegWrite = w_ctrl.reg_write & ~reset;
  assign PCEn     = ~reset & (w_ctrl.pc_write | (w_ctrl.branch & Zero));
  assign State    = w_state_eff;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction step model; a monitor
// compares every cycle's full output vector with the queued expectation.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc    = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .State(State)
  );

  always #5 clk = ~clk;

  // Vector: {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
  //          ALUSrcB, ALUOp, PCSrc, PCEn}
  function automatic logic [17:0] pack(int st, bit iord, bit mw, bit irw, bit rd,
                                       bit m2r, bit rw, bit sa, logic [1:0] sb,
                                       logic [1:0] aop, logic [1:0] pcs, bit pce);
    logic [3:0] s4;
    s4 = st[3:0];
    return {s4, iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, pce};
  endfunction

  // Expected outputs for one named instruction step, straight from the step table.
  function automatic logic [17:0] model(int st, bit z, bit rst);
    if (rst) return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    case (st)
      0:  return pack(0,  0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1);
      1:  return pack(1,  0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
      2:  return pack(2,  0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      3:  return pack(3,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      4:  return pack(4,  0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      5:  return pack(5,  1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      6:  return pack(6,  0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      7:  return pack(7,  0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      8:  return pack(8,  0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, z);
      9:  return pack(9,  0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      10: return pack(10, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      11: return pack(11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1);
      default: return '0;
    endcase
  endfunction

  // Step list an instruction walks through, by opcode.
  task automatic steps_for(input logic [5:0] op, output int seq[$]);
    seq = {0, 1};
    case (op)
      6'b100011: seq = {seq, 2, 3, 4};
      6'b101011: seq = {seq, 2, 5};
      6'b000000: seq = {seq, 6, 7};
      6'b000100: seq = {seq, 8};
      6'b001000: seq = {seq, 9, 10};
      6'b000010: seq = {seq, 11};
      default: ;
    endcase
  endtask

  task automatic drive_cycle(input int st, input logic [5:0] op, input bit rst,
                             input int zmode);
    @(posedge clk);
    #1;
    reset = rst;
    Op    = op;
    Zero  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    exp_q.push_back(model(st, Zero, rst));
  endtask

  // cut < 0 runs to completion; otherwise reset is raised for rcyc cycles at step cut.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int cut,
                           input int rcyc);
    int seq[$];
    steps_for(op, seq);
    foreach (seq[i]) begin
      if (cut >= 0 && i == cut) begin
        for (int r = 0; r < rcyc; r++) drive_cycle(0, op, 1'b1, -1);
        return;
      end
      drive_cycle(seq[i], op, 1'b0, (seq[i] == 8) ? zmode : -1);
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops[6];
    logic [5:0] o;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    if ($urandom_range(0, 6) < 6) return ops[$urandom_range(0, 5)];
    do o = 6'($urandom_range(0, 63));
    while (o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
    return o;
  endfunction

  always @(negedge clk) begin
    logic [17:0] act, exp;
    n_cyc++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, ALUOp, PCSrc, PCEn};
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL cyc%0d_outputs got %b want %b (State %0d want %0d)",
                    n_cyc, act, exp, act[17:14], exp[17:14]);
    end
  end

  initial begin
    drive_cycle(0, 6'd0, 1'b1, -1);
    drive_cycle(0, 6'd0, 1'b1, -1);
    run_instr(6'b000000, -1, 2, 2);
    run_instr(6'b100011, -1, -1, 0);
    run_instr(6'b101011, -1, -1, 0);
    run_instr(6'b000000, -1, -1, 0);
    run_instr(6'b000100, 1, -1, 0);
    run_instr(6'b000100, 0, -1, 0);
    run_instr(6'b001000, -1, -1, 0);
    run_instr(6'b000010, -1, -1, 0);
    run_instr(6'b111111, -1, -1, 0);
    run_instr(6'b100011, -1, 3, 1);
    for (int k = 0; k < 80; k++) run_instr(rand_op(), -1, -1, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
